lsu_mem_initiator: RTL

//  Initiator side of the data-memory load/store interface. Accepts one load/store

---
 rtl/lsu_mem_initiator_pkg.sv | 49 ++++
 rtl/lsu_data_align.sv | 48 ++++
 rtl/lsu_mem_initiator.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lsu_mem_initiator_pkg.sv
// Shared definitions for the LSU memory initiator: access-type encodings, FSM states,
// default timeout and the alignment/legality check applied when a request is accepted.
package lsu_mem_initiator_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // Load encodings
  localparam logic [2:0] LS_W  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_HU = 3'b010;
  localparam logic [2:0] LS_B  = 3'b011;
  localparam logic [2:0] LS_BU = 3'b100;

  // Store encodings
  localparam logic [2:0] ST_W  = 3'b000;
  localparam logic [2:0] ST_H  = 3'b001;
  localparam logic [2:0] ST_B  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  function automatic logic access_ok(input logic we, input logic [2:0] lstype,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (lstype)
        ST_W:    ok = (addr_lo == 2'b00);
        ST_H:    ok = !addr_lo[0];
        ST_B:    ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end else begin
      case (lstype)
        LS_W:        ok = (addr_lo == 2'b00);
        LS_H, LS_HU: ok = !addr_lo[0];
        LS_B, LS_BU: ok = 1'b1;
        default:     ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering for a word-only memory: extracts and extends sub-word loads and
// merges sub-word store data into a previously read word.
module lsu_data_align
  import lsu_mem_initiator_pkg::*;
(
  input  logic [2:0]  lstype,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic signed [15:0] half_sel;
  logic signed [7:0]  byte_sel;

  always_comb begin
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    // lstype is read with load meaning here and with store meaning below
    case (lstype)
      LS_W:    load_data = rdata;
      LS_H:    load_data = 32'(half_sel);
      LS_HU:   load_data = {16'h0000, half_sel};
      LS_B:    load_data = 32'(byte_sel);
      LS_BU:   load_data = {24'h000000, byte_sel};
      default: load_data = rdata;
    endcase

    store_data = rdata;
    case (lstype)
      ST_W: store_data = wdata;
      ST_H: begin
        if (addr_lo[1]) store_data[31:16] = wdata[15:0];
        else            store_data[15:0]  = wdata[15:0];
      end
      ST_B:    store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      default: store_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator: word-only memory port with req/ack handshake,
// read-modify-write for sub-word stores, and an ack timeout that aborts with an error.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_lstype,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state, state_n;
  logic             we_q, we_n;
  logic [2:0]       lstype_q, lstype_n;
  logic [31:0]      addr_q, addr_n;
  logic [31:0]      sdata_q, sdata_n;
  logic [31:0]      wdata_q, wdata_n;
  logic [31:0]      rdata_q, rdata_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [31:0]      load_data, store_data;

  lsu_data_align u_align (
    .lstype     (lstype_q),
    .addr_lo    (addr_q[1:0]),
    .rdata      (mem_rdata),
    .wdata      (sdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      we_q     <= 1'b0;
      lstype_q <= 3'b000;
      addr_q   <= 32'h0;
      sdata_q  <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      cnt_q    <= '0;
    end else begin
      state    <= state_n;
      we_q     <= we_n;
      lstype_q <= lstype_n;
      addr_q   <= addr_n;
      sdata_q  <= sdata_n;
      wdata_q  <= wdata_n;
      rdata_q  <= rdata_n;
      cnt_q    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    we_n     = we_q;
    lstype_n = lstype_q;
    addr_n   = addr_q;
    sdata_n  = sdata_q;
    wdata_n  = wdata_q;
    rdata_n  = rdata_q;
    cnt_n    = cnt_q;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          we_n     = req_we;
          lstype_n = req_lstype;
          addr_n   = req_addr;
          sdata_n  = req_wdata;
          cnt_n    = '0;
          if (!access_ok(req_we, req_lstype, req_addr[1:0])) begin
            state_n = S_ERR;
          end else if (req_we && (req_lstype == ST_W)) begin
            wdata_n = req_wdata;
            state_n = S_WR;
          end else begin
            state_n = S_RD;
          end
        end
      end
      S_RD: begin
        if (mem_ack) begin
          cnt_n = '0;
          if (we_q) begin
            wdata_n = store_data;
            state_n = S_WR;
          end else begin
            rdata_n = load_data;
            state_n = S_RESP;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          state_n = S_ERR;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_WR: begin
        if (mem_ack) begin
          state_n = S_RESP;
        end else if (cnt_q == CNT_LIMIT) begin
          state_n = S_ERR;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake outputs decode directly from the registered state
  assign req_ready  = (state == S_IDLE);
  assign mem_req    = (state == S_RD) || (state == S_WR);
  assign mem_we     = (state == S_WR);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;
  assign resp_valid = (state == S_RESP) || (state == S_ERR);
  assign resp_err   = (state == S_ERR);
  assign resp_rdata = ((state == S_RESP) && !we_q) ? rdata_q : 32'h0;

endmodule
